// File: rtl/seg_pkg.sv
// seg_pkg: shared constants and helpers for the
// scanned 7-segment data selector.
package seg_pkg;

  localparam int   DIV_SIM   = 4;
  localparam int   DIV_BOARD = 50000;
  localparam logic BLANK_BIT = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// tick_gen: parametrised prescaler, one-cycle tick
// at terminal count, frozen while hold is high.
module tick_gen
  import seg_pkg::*;
#(
  parameter int DIV = DIV_BOARD
) (
  input  logic clk,
  input  logic rst,
  input  logic hold,
  output logic tick
);

  localparam int CW = clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (!hold) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  assign tick = !hold && (cnt == LAST);

endmodule

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexed N-channel selector
// with registered word and active-low digit strobe.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int DIV      = DIV_BOARD,
  parameter logic [WIDTH-1:0] BLANK = {WIDTH{BLANK_BIT}}
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CHANNELS*WIDTH-1:0]    data,
  input  logic [CHANNELS-1:0]          en,
  input  logic                         scan,
  input  logic [clog2(CHANNELS)-1:0]   sel,
  input  logic                         hold,
  output logic [WIDTH-1:0]             o,
  output logic [CHANNELS-1:0]          an,
  output logic [clog2(CHANNELS)-1:0]   ch,
  output logic                         tick
);

  localparam int SW = clog2(CHANNELS);

  logic [SW-1:0] nxt;
  logic [SW-1:0] fix_sel;

  tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .hold (hold),
    .tick (tick)
  );

  // first enabled channel after ch, wrapping; ch if none
  always_comb begin
    int  j;
    logic found;
    nxt   = ch;
    found = 1'b0;
    j     = 0;
    for (int i = 1; i < CHANNELS; i++) begin
      j = int'(ch) + i;
      if (j >= CHANNELS) j = j - CHANNELS;
      if (!found && en[j]) begin
        nxt   = SW'(j);
        found = 1'b1;
      end
    end
  end

  assign fix_sel = (int'(sel) >= CHANNELS) ? '0 : sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      ch <= '0;
    end else if (!hold) begin
      if (!scan) begin
        ch <= fix_sel;
      end else if (tick) begin
        ch <= nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o  <= BLANK;
      an <= '1;
    end else if (en[ch]) begin
      o  <= data[int'(ch)*WIDTH +: WIDTH];
      an <= ~(CHANNELS'(1) << ch);
    end else begin
      o  <= BLANK;
      an <= '1;
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb_seg_scan_mux: directed checks of scan, skip,
// blanking, fixed select, hold and reset priority.
module tb_seg_scan_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data;
  logic [3:0]  en;
  logic        scan;
  logic [1:0]  sel;
  logic        hold;
  logic [7:0]  o;
  logic [3:0]  an;
  logic [1:0]  ch;
  logic        tick;

  logic [23:0] data3;
  logic [2:0]  en3;
  logic        scan3;
  logic [1:0]  sel3;
  logic [7:0]  o3;
  logic [2:0]  an3;
  logic [1:0]  ch3;
  logic        tick3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seg_scan_mux #(
    .CHANNELS (4),
    .WIDTH    (8),
    .DIV      (4)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .data (data),
    .en   (en),
    .scan (scan),
    .sel  (sel),
    .hold (hold),
    .o    (o),
    .an   (an),
    .ch   (ch),
    .tick (tick)
  );

  seg_scan_mux #(
    .CHANNELS (3),
    .WIDTH    (8),
    .DIV      (4)
  ) dut3 (
    .clk  (clk),
    .rst  (rst),
    .data (data3),
    .en   (en3),
    .scan (scan3),
    .sel  (sel3),
    .hold (1'b0),
    .o    (o3),
    .an   (an3),
    .ch   (ch3),
    .tick (tick3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    while (tick !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("tick_seen", 32'(tick), 32'd1);
  endtask

  logic [1:0] exp_ch [4] = '{2'd3, 2'd1, 2'd3, 2'd1};
  logic [7:0] exp_o  [4] = '{8'h44, 8'h22, 8'h44, 8'h22};
  logic [3:0] exp_an [4] = '{4'h7, 4'hD, 4'h7, 4'hD};

  initial begin
    int n;
    int ticks;
    rst   = 1'b1;
    data  = 32'h44332211;
    en    = 4'hF;
    scan  = 1'b1;
    sel   = 2'd0;
    hold  = 1'b0;
    data3 = 24'hCCBBAA;
    en3   = 3'b111;
    scan3 = 1'b0;
    sel3  = 2'd2;

    // reset
    step();
    chk("rst_ch", 32'(ch), 32'd0);
    chk("rst_o", 32'(o), 32'hFF);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_tick", 32'(tick), 32'd0);
    rst = 1'b0;

    step();
    chk("e1_o", 32'(o), 32'h11);
    chk("e1_an", 32'(an), 32'hE);
    chk("e1_ch", 32'(ch), 32'd0);
    chk("e1_tick", 32'(tick), 32'd0);
    step();
    step();
    chk("e3_tick", 32'(tick), 32'd1);
    step();
    chk("e4_ch", 32'(ch), 32'd1);
    chk("e4_tick", 32'(tick), 32'd0);
    chk("e4_o", 32'(o), 32'h11);
    step();
    chk("e5_o", 32'(o), 32'h22);
    chk("e5_an", 32'(an), 32'hD);

    // skip disabled channels
    en = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      wait_tick(n);
      if (k > 0) chk("skip_dwell", 32'(n), 32'd2);
      step();
      chk("skip_ch", 32'(ch), 32'(exp_ch[k]));
      step();
      chk("skip_o", 32'(o), 32'(exp_o[k]));
      chk("skip_an", 32'(an), 32'(exp_an[k]));
    end

    // all disabled
    en = 4'h0;
    step();
    chk("off_o", 32'(o), 32'hFF);
    chk("off_an", 32'(an), 32'hF);
    wait_tick(n);
    chk("off_ch0", 32'(ch), 32'd1);
    step();
    chk("off_ch1", 32'(ch), 32'd1);
    wait_tick(n);
    chk("off_period", 32'(n), 32'd3);
    chk("off_ch2", 32'(ch), 32'd1);

    // fixed select
    en   = 4'hF;
    scan = 1'b0;
    sel  = 2'd2;
    step();
    chk("fix_ch", 32'(ch), 32'd2);
    step();
    chk("fix_o", 32'(o), 32'h33);
    chk("fix_an", 32'(an), 32'hB);
    wait_tick(n);
    step();
    chk("fix_tick_ch", 32'(ch), 32'd2);

    // hold: cnt is 0 here, one edge takes it to 1
    scan = 1'b1;
    step();
    chk("pre_hold_ch", 32'(ch), 32'd2);
    hold  = 1'b1;
    data  = 32'h445A2211;
    ticks = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (tick) ticks++;
    end
    chk("hold_ticks", 32'(ticks), 32'd0);
    chk("hold_ch", 32'(ch), 32'd2);
    chk("hold_o", 32'(o), 32'h5A);
    hold = 1'b0;
    data = 32'h44332211;
    wait_tick(n);
    chk("hold_resume", 32'(n), 32'd2);
    step();
    chk("hold_next_ch", 32'(ch), 32'd3);

    // mid-dwell disable of channel 2
    scan = 1'b0;
    sel  = 2'd2;
    step();
    chk("md_ch", 32'(ch), 32'd2);
    scan = 1'b1;
    en   = 4'b1011;
    step();
    chk("md_o", 32'(o), 32'hFF);
    chk("md_an", 32'(an), 32'hF);
    wait_tick(n);
    step();
    chk("md_skip_ch", 32'(ch), 32'd3);

    // reset beats hold
    en = 4'hF;
    step();
    chk("pre_rst_o", 32'(o), 32'h44);
    hold = 1'b1;
    rst  = 1'b1;
    step();
    chk("rh_ch", 32'(ch), 32'd0);
    chk("rh_o", 32'(o), 32'hFF);
    chk("rh_an", 32'(an), 32'hF);
    chk("rh_tick", 32'(tick), 32'd0);
    rst  = 1'b0;
    hold = 1'b0;
    wait_tick(n);
    chk("rh_cnt0", 32'(n), 32'd3);

    // out-of-range select on a 3-channel instance
    sel3 = 2'd2;
    step();
    chk("c3_ch2", 32'(ch3), 32'd2);
    sel3 = 2'd3;
    step();
    chk("c3_oor_ch", 32'(ch3), 32'd0);
    step();
    chk("c3_oor_o", 32'(o3), 32'hAA);
    chk("c3_oor_an", 32'(an3), 32'h6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
